// File: rtl/cgra_mem_pkg.sv
// Shared CGRA memory-path definitions: default widths and the request-entry layout
// used by the request queue, the round-robin arbiter and the memory bank.
package cgra_mem_pkg;

  localparam int NUM_PORTS_DEF  = 5;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int ADDR_W_DEF     = 8;
  localparam int DATA_W_DEF     = 16;

  // A queued request is packed MSB-first as {we, addr, wdata}.
  function automatic int entry_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

  // Outcome of checking the arbiter's grant vector in a given cycle.
  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_OK   = 2'd1,
    GNT_ERR  = 2'd2
  } gnt_status_e;

endpackage

// File: rtl/req_fifo.sv
// Single-port circular request queue: one push and one pop per cycle, exposes the
// head entry and the occupancy count. The caller never pushes when full or pops when empty.
module req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 25
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [W-1:0]     mem_q [DEPTH];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; a cleared count makes stale
  // entries unreachable, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/mem_req_queue.sv
// Per-port request queues in front of a registered round-robin arbiter; validates
// the grant vector, pops the granted head and registers it toward shared memory.
module mem_req_queue
  import cgra_mem_pkg::*;
#(
  parameter int NUM_PORTS  = NUM_PORTS_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  localparam int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        in_valid,
  output logic [NUM_PORTS-1:0]        in_ready,
  input  logic [NUM_PORTS-1:0]        in_we,
  input  logic [NUM_PORTS*ADDR_W-1:0] in_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] in_wdata,
  output logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        gnt,
  output logic                        mem_valid,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic [PORT_W-1:0]           mem_port,
  output logic                        gnt_err
);

  localparam int ENTRY_W = entry_w(ADDR_W, DATA_W);
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_PORTS-1:0] push;
  logic [NUM_PORTS-1:0] pop;
  logic [ENTRY_W-1:0]   head  [NUM_PORTS];
  logic [CNT_W-1:0]     count [NUM_PORTS];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    req_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (ENTRY_W)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[g]),
      .pop   (pop[g]),
      .wdata ({in_we[g], in_addr[g*ADDR_W +: ADDR_W], in_wdata[g*DATA_W +: DATA_W]}),
      .head  (head[g]),
      .count (count[g])
    );
  end

  // A full queue refuses even when it pops this cycle. The entry under grant is
  // masked from req so the registered arbiter cannot re-grant an emptied queue.
  // NOTE: every always_comb output gets a value on every path to avoid latches.
  always_comb begin
    in_ready = '0;
    push     = '0;
    req      = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      in_ready[i] = !rst && (count[i] != CNT_W'(FIFO_DEPTH));
      push[i]     = in_valid[i] && in_ready[i];
      req[i]      = !rst && ((count[i] > CNT_W'(1)) ||
                             ((count[i] == CNT_W'(1)) && !gnt[i]));
    end
  end

  logic [PORT_W-1:0] gnt_idx;
  logic              gnt_onehot;
  gnt_status_e       gnt_status;

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gnt[i]) begin
        gnt_idx = PORT_W'(i);
      end
    end
    gnt_onehot = (gnt != '0) && ((gnt & (gnt - NUM_PORTS'(1))) == '0);
    if (gnt == '0) begin
      gnt_status = GNT_IDLE;
    end else if (gnt_onehot && (count[gnt_idx] != '0)) begin
      gnt_status = GNT_OK;
    end else begin
      gnt_status = GNT_ERR;
    end
    pop = (gnt_status == GNT_OK) ? gnt : '0;
  end

  logic              mem_valid_q, mem_valid_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [PORT_W-1:0] mem_port_q,  mem_port_d;
  logic              gnt_err_q,   gnt_err_d;

  // Issue fields only change on a good grant; idle and bad grants hold them.
  always_comb begin
    mem_valid_d = 1'b0;
    gnt_err_d   = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_port_d  = mem_port_q;
    unique case (gnt_status)
      GNT_OK: begin
        mem_valid_d                           = 1'b1;
        {mem_we_d, mem_addr_d, mem_wdata_d}   = head[gnt_idx];
        mem_port_d                            = gnt_idx;
      end
      GNT_ERR: gnt_err_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_port_q  <= '0;
      gnt_err_q   <= 1'b0;
    end else begin
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_port_q  <= mem_port_d;
      gnt_err_q   <= gnt_err_d;
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_port  = mem_port_q;
  assign gnt_err   = gnt_err_q;

endmodule

// File: tb/tb_mem_req_queue.sv
// Scoreboard bench for mem_req_queue: directed scenarios plus randomized traffic,
// checked against per-port FIFO queues and a model of the issue register.
module tb_mem_req_queue;

  localparam int NP = 5;
  localparam int D  = 4;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int PW = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NP-1:0]   in_valid = '0;
  logic [NP-1:0]   in_ready;
  logic [NP-1:0]   in_we = '0;
  logic [NP*AW-1:0] in_addr = '0;
  logic [NP*DW-1:0] in_wdata = '0;
  logic [NP-1:0]   req;
  logic [NP-1:0]   gnt = '0;
  logic            mem_valid;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [PW-1:0]   mem_port;
  logic            gnt_err;

  mem_req_queue #(
    .NUM_PORTS  (NP),
    .FIFO_DEPTH (D),
    .ADDR_W     (AW),
    .DATA_W     (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_we     (in_we),
    .in_addr   (in_addr),
    .in_wdata  (in_wdata),
    .req       (req),
    .gnt       (gnt),
    .mem_valid (mem_valid),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_port  (mem_port),
    .gnt_err   (gnt_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    bit [AW-1:0] addr;
    bit [DW-1:0] wdata;
  } ent_t;

  typedef struct {
    bit          valid;
    bit          err;
    bit          we;
    bit [AW-1:0] addr;
    bit [DW-1:0] wdata;
    bit [PW-1:0] port;
  } out_t;

  ent_t mq [NP][$];
  out_t exp_q [$];
  out_t last;
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs, check the combinational outputs against the
  // model, advance the model across the coming edge and queue the expected issue.
  task automatic step(input bit r, input logic [NP-1:0] v, input logic [NP-1:0] we,
                      input logic [NP*AW-1:0] a, input logic [NP*DW-1:0] d,
                      input logic [NP-1:0] g);
    logic [NP-1:0] er;
    logic [NP-1:0] eq;
    int            idx;
    int            sz;
    ent_t          e;
    rst = r; in_valid = v; in_we = we; in_addr = a; in_wdata = d; gnt = g;
    #1;
    for (int i = 0; i < NP; i++) begin
      sz    = mq[i].size();
      er[i] = !r && (sz != D);
      eq[i] = !r && ((sz > 1) || (sz == 1 && !g[i]));
    end
    check("in_ready", 32'(in_ready), 32'(er));
    check("req", 32'(req), 32'(eq));
    if (r) begin
      for (int i = 0; i < NP; i++) mq[i].delete();
      last = '{default: 0};
    end else begin
      last.valid = 1'b0;
      last.err   = 1'b0;
      if ($countones(g) == 1) begin
        idx = 0;
        for (int i = 0; i < NP; i++) if (g[i]) idx = i;
        if (mq[idx].size() > 0) begin
          e          = mq[idx].pop_front();
          last.valid = 1'b1;
          last.we    = e.we;
          last.addr  = e.addr;
          last.wdata = e.wdata;
          last.port  = PW'(idx);
        end else begin
          last.err = 1'b1;
        end
      end else if (g != '0) begin
        last.err = 1'b1;
      end
      for (int i = 0; i < NP; i++) begin
        if (v[i] && er[i]) mq[i].push_back('{we[i], a[i*AW +: AW], d[i*DW +: DW]});
      end
    end
    exp_q.push_back(last);
    @(negedge clk);
  endtask

  // Monitor: after each rising edge pop the expected issue and compare.
  initial begin
    out_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("mem_valid", 32'(mem_valid), 32'(x.valid));
        check("gnt_err", 32'(gnt_err), 32'(x.err));
        check("mem_we", 32'(mem_we), 32'(x.we));
        check("mem_addr", 32'(mem_addr), 32'(x.addr));
        check("mem_wdata", 32'(mem_wdata), 32'(x.wdata));
        check("mem_port", 32'(mem_port), 32'(x.port));
      end
    end
  end

  function automatic logic [NP-1:0] pick_gnt();
    logic [NP-1:0] g = '0;
    int            cand [$];
    int            mode = int'($urandom_range(0, 9));
    if (mode <= 4) begin
      for (int i = 0; i < NP; i++) if (mq[i].size() > 0) cand.push_back(i);
      if (cand.size() > 0) g[cand[$urandom_range(0, cand.size() - 1)]] = 1'b1;
    end else if (mode == 6) begin
      do g = NP'($urandom); while ($countones(g) < 2);
    end else if (mode == 7) begin
      for (int i = 0; i < NP; i++) if (mq[i].size() == 0) cand.push_back(i);
      if (cand.size() > 0) g[cand[$urandom_range(0, cand.size() - 1)]] = 1'b1;
    end else if (mode == 8) begin
      g[$urandom_range(0, NP - 1)] = 1'b1;
    end
    return g;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NP*AW-1:0] a;
    logic [NP*DW-1:0] d;
    logic [NP-1:0]    v;
    logic [NP-1:0]    we;
    @(negedge clk);
    step(1, '0, '0, '0, '0, '0);
    step(1, '0, '0, '0, '0, '0);

    // Single write on port 2, granted one cycle after it shows on req.
    a = '0; d = '0;
    a[2*AW +: AW] = 8'h3C;
    d[2*DW +: DW] = 16'hBEEF;
    step(0, 5'b00100, 5'b00100, a, d, '0);
    step(0, '0, '0, '0, '0, '0);
    step(0, '0, '0, '0, '0, 5'b00100);
    step(0, '0, '0, '0, '0, '0);

    // Fill port 0, attempt a fifth push, then pop once.
    for (int k = 0; k < 5; k++) begin
      a = '0; d = '0;
      a[0 +: AW] = AW'(8'h10 + k);
      d[0 +: DW] = DW'(16'h1000 + k);
      step(0, 5'b00001, NP'(k & 1), a, d, '0);
    end
    step(0, '0, '0, '0, '0, 5'b00001);
    step(0, '0, '0, '0, '0, '0);

    // Multi-hot grant, then one-hot grant to empty port 3.
    a = '0; d = '0;
    a[1*AW +: AW] = 8'h51;
    d[1*DW +: DW] = 16'h5151;
    step(0, 5'b00010, '0, a, d, '0);
    step(0, '0, '0, '0, '0, 5'b00011);
    step(0, '0, '0, '0, '0, 5'b01000);
    step(0, '0, '0, '0, '0, '0);

    // Port 1 holds one entry: push and grant together.
    a = '0; d = '0;
    a[1*AW +: AW] = 8'h52;
    d[1*DW +: DW] = 16'h5252;
    step(0, 5'b00010, 5'b00010, a, d, 5'b00010);
    step(0, '0, '0, '0, '0, '0);

    // Fill ports 0/2/4, reset for one cycle, check release state.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < NP; i++) begin
        a[i*AW +: AW] = AW'($urandom);
        d[i*DW +: DW] = DW'($urandom);
      end
      step(0, 5'b10101, NP'($urandom), a, d, '0);
    end
    step(1, 5'b10101, '0, a, d, 5'b00001);
    step(0, '0, '0, '0, '0, '0);
    step(0, '0, '0, '0, '0, '0);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < NP; i++) begin
        a[i*AW +: AW] = AW'($urandom);
        d[i*DW +: DW] = DW'($urandom);
        v[i]          = ($urandom_range(0, 9) < 6);
        we[i]         = $urandom_range(0, 1) == 1;
      end
      step($urandom_range(0, 149) == 0, v, we, a, d, pick_gnt());
    end
    step(0, '0, '0, '0, '0, '0);

    repeat (2) @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_req_queue.md
MEM_REQ_QUEUE -- requirements
Module: mem_req_queue

Interface
REQ-001 Parameter NUM_PORTS, default 5: number of requesting CGRA ports; equals the downstream round-robin arbiter's Req_Width.
REQ-002 Parameter FIFO_DEPTH, default 4: entries per port queue; power of two, at least 2.
REQ-003 Parameter ADDR_W, default 8: shared-memory address width.
REQ-004 Parameter DATA_W, default 16: shared-memory data width.
REQ-005 One clock and one reset; reset is synchronous and active-high.
REQ-006 clk  in  1  single clock; all state updates on the rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 in_valid  in  NUM_PORTS  per-port request valid.
REQ-009 in_ready  out  NUM_PORTS  per-port queue can accept.
REQ-010 in_we  in  NUM_PORTS  per-port write enable (1 = write, 0 = read).
REQ-011 in_addr  in  NUM_PORTS*ADDR_W  per-port address; port i occupies bits [i*ADDR_W +: ADDR_W].
REQ-012 in_wdata  in  NUM_PORTS*DATA_W  per-port write data; port i occupies bits [i*DATA_W +: DATA_W].
REQ-013 req  out  NUM_PORTS  request vector to the arbiter.
REQ-014 gnt  in  NUM_PORTS  registered grant vector from the arbiter.
REQ-015 mem_valid  out  1  issued request valid toward shared memory.
REQ-016 mem_we, mem_addr, mem_wdata  out  1/ADDR_W/DATA_W  issued request fields.
REQ-017 mem_port  out  clog2(NUM_PORTS)  index of the issuing port.
REQ-018 gnt_err  out  1  grant protocol violation pulse.

Function
REQ-019 Each port has an independent circular queue of {we, addr, wdata}; head and tail pointers wrap modulo FIFO_DEPTH; count is clog2(FIFO_DEPTH)+1 bits wide.
REQ-020 in_ready[i] = (count[i] != FIFO_DEPTH) and not rst, combinational.
REQ-021 A push occurs when in_valid[i] and in_ready[i] are both high; a full queue never accepts, even if it pops in the same cycle.
REQ-022 req[i] = (count[i] > 1) or (count[i] == 1 and not gnt[i]), combinational; the entry being popped this cycle is masked so that the registered arbiter cannot grant an empty queue.
REQ-023 A grant is valid when gnt is one-hot and the granted queue is non-empty; on a valid grant the head entry pops at that rising edge.
REQ-024 Pop-to-issue latency is one cycle: next cycle mem_valid=1, and mem_we/mem_addr/mem_wdata/mem_port carry the popped entry and port index.
REQ-025 gnt all-zero: no pop; mem_valid=0 next cycle; the other mem_* fields hold their values.
REQ-026 gnt multi-hot, or one-hot to an empty queue: no pop on any port; mem_valid=0 and gnt_err=1 next cycle for one cycle.
REQ-027 Simultaneous push and pop on the same port: both take effect and count is unchanged; FIFO order is preserved.
REQ-028 A push into an empty queue is not visible on req until the following cycle; there is no bypass.

Reset
REQ-029 While rst=1 at a rising edge: all pointers and counts cleared, queue contents discarded, mem_valid/mem_we/mem_addr/mem_wdata/mem_port/gnt_err = 0; in_ready = 0 and req = 0 during reset.
REQ-030 Reset asserted mid-operation drops all queued and in-flight requests; there is no issue in the cycle after reset.

Structure
REQ-031 Shared package cgra_mem_pkg holds ADDR_W, DATA_W, NUM_PORTS defaults and the request-entry field layout, shared with the arbiter and memory bank.
REQ-032 One sub-module req_fifo (single-port circular queue with push, pop and count) is instantiated NUM_PORTS times; grant checking and the issue register live in the top.

Verification
REQ-033 Reset, then push port 2 {we=1, addr=0x3C, wdata=0xBEEF}: req=5'b00100 one cycle later; gnt=5'b00100 -> next cycle mem_valid=1, addr=0x3C, wdata=0xBEEF, mem_port=2; req=0 during the grant cycle.
REQ-034 Push 4 entries to port 0: in_ready[0]=0; a 5th push is not accepted; pop once -> in_ready[0]=1 the following cycle.
REQ-035 gnt=5'b00011 with both queues non-empty -> no pop, gnt_err=1 for one cycle, mem_valid=0, counts unchanged.
REQ-036 gnt=5'b01000 with port 3 empty -> gnt_err=1, mem_valid=0, no count change.
REQ-037 Port 1 count=1, push and grant in the same cycle -> count stays 1, the issued entry is the old head, req[1]=1 next cycle.
REQ-038 Queues 0/2/4 full, rst=1 for one cycle -> all counts 0, req=0, mem_valid=0, in_ready=5'b11111 after release.
